alu_arb_seq: RTL and testbench
==============================

Name: alu_arb_seq

Overview:
- Shares one 4-bit ALU (add, sub, mul, pass-x) between two requesters.
- Uses round-robin arbitration.
- Sequences each operation: add/sub/pass take a single execute cycle; mul runs as an iterative shift-add over DATA_W cycles.
- Sits between the two operand sources and the result consumer.
- Returns an 8-bit result tagged with the requester id.

Parameters:
- DATA_W, 4, operand width; result width is 2*DATA_W (derived localparam RES_W).

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- req_i  input  2  per-requester request; held until acked
- op0_i  input  2  requester 0 opcode (00 add, 01 sub, 10 mul, 11 pass x)
- x0_i  input  DATA_W  requester 0 operand x
- y0_i  input  DATA_W  requester 0 operand y
- op1_i  input  2  requester 1 opcode
- x1_i  input  DATA_W  requester 1 operand x
- y1_i  input  DATA_W  requester 1 operand y
- ack_o  output  2  one-hot capture acknowledge (combinational)
- busy_o  output  1  high while state != IDLE
- res_valid_o  output  1  one-cycle result strobe
- res_id_o  output  1  requester index of result
- res_o  output  RES_W  result

Behaviour:
- Reset values:
  - clock is clk; reset is synchronous and active-high; all state changes on the rising edge of clk.
  - state=IDLE, ack_o=0, busy_o=0, res_valid_o=0, res_id_o=0, res_o=0, last_grant=1 (requester 0 wins first tie).
- FSM states: IDLE, EXEC, MUL.
- IDLE:
  - If any req_i bit is set, grant it.
  - If both are set, grant the index != last_grant.
  - ack_o[g]=1 in that same cycle.
  - At the edge: latch op/x/y of g, set last_grant=g, go to MUL if op=10, else EXEC.
- EXEC: compute the result, register res_o, res_id_o=g, res_valid_o=1 in the next cycle, return to IDLE.
- MUL:
  - Init acc=0, mcand=x, mplier=y.
  - Each cycle: if mplier[0], acc += mcand<<i; decrement counter.
  - After DATA_W cycles (counter reaches 0), register the result, pulse res_valid_o, return to IDLE.
- Latency (ack in cycle T):
  - add/sub/pass: res_valid_o in T+2.
  - mul: res_valid_o in T+DATA_W+2 (T+6 at default).
- Throughput: a new request may be acked in the same cycle res_valid_o is high, because state is IDLE then.
- ack_o is 0 in EXEC and MUL. Requests arriving then wait; req_i must stay asserted and operands stable until ack.
- Arithmetic:
  - add: zero-extended sum (15+15 = 8'h1E).
  - sub: two's complement x-y sign-extended to RES_W (3-5 = 8'hFE).
  - mul: unsigned full product (15*15 = 8'hE1).
  - pass: {0, x}.
- res_o holds its value between strobes.
- A request dropped before ack is not serviced. A request dropped after ack does not affect the operation.
- Reset mid-operation aborts it: no res_valid_o pulse, and last_grant returns to 1.
- A single requester continuously requesting is served back-to-back. With both requesting, grants strictly alternate.

Optional Feature:
- Macro ALU_ARB_STATUS_EN.
- Defined:
  - Adds outputs zero_o (1b) and neg_o (1b), registered alongside res_o and valid with res_valid_o.
  - zero_o = (res_o==0).
  - neg_o = res_o[RES_W-1], and only for sub; 0 for other ops.
  - Both reset to 0.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package alu_pkg:
  - opcode constants OP_ADD=2'b00, OP_SUB=2'b01, OP_MUL=2'b10, OP_PASS=2'b11;
  - FSM state encoding (IDLE, EXEC, MUL);
  - default DATA_W.
- Sub-module alu_mul_shift: the iterative shift-add multiplier.
  - start/done handshake; DATA_W-cycle latency.
  - Instantiated once; the FSM waits in MUL for done.

Test Plan:
- Reset, then req_i=01, op0=00, x0=9, y0=7 -> ack_o=01 in T; res_valid_o in T+2 with res_o=8'h10, res_id_o=0.
- req_i=10, op1=01, x1=3, y1=5 -> res_o=8'hFE, res_id_o=1; with ALU_ARB_STATUS_EN, neg_o=1 and zero_o=0.
- req_i=01, op0=10, x0=15, y0=15 -> busy_o high T+1..T+5; res_valid_o at T+6 with res_o=8'hE1; a req_i[1] raised at T+2 is not acked until T+6.
- Both requesters held continuously with op=pass, x0=1, x1=2 -> grant order 0,1,0,1; res_o sequence 1,2,1,2; results spaced 2 cycles apart.
- Assert reset at T+3 of a mul -> no res_valid_o pulse; outputs return to reset values; next tie is granted to requester 0.
- x0=0, y0=0, op=sub -> res_o=0; with ALU_ARB_STATUS_EN, zero_o=1 and neg_o=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the arbitrated ALU: opcodes, FSM encoding and the default operand width.
package alu_pkg;

    localparam int DATA_W_DEFAULT = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2
    } state_t;

endpackage

// File: rtl/alu_arb_seq_if.sv
// Request/ack and result bus between two operand sources, the shared ALU and the result consumer.
// Optional status flags appear when ALU_ARB_STATUS_EN is defined.
interface alu_arb_seq_if
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
);
    localparam int RES_W = 2 * DATA_W;

    logic [1:0]        req_i;
    logic [1:0]        op0_i;
    logic [DATA_W-1:0] x0_i;
    logic [DATA_W-1:0] y0_i;
    logic [1:0]        op1_i;
    logic [DATA_W-1:0] x1_i;
    logic [DATA_W-1:0] y1_i;
    logic [1:0]        ack_o;
    logic              busy_o;
    logic              res_valid_o;
    logic              res_id_o;
    logic [RES_W-1:0]  res_o;
`ifdef ALU_ARB_STATUS_EN
    logic              zero_o;
    logic              neg_o;
`endif

    modport master (
        output req_i, op0_i, x0_i, y0_i, op1_i, x1_i, y1_i,
`ifdef ALU_ARB_STATUS_EN
        input  zero_o, neg_o,
`endif
        input  ack_o, busy_o, res_valid_o, res_id_o, res_o
    );

    modport slave (
        input  req_i, op0_i, x0_i, y0_i, op1_i, x1_i, y1_i,
`ifdef ALU_ARB_STATUS_EN
        output zero_o, neg_o,
`endif
        output ack_o, busy_o, res_valid_o, res_id_o, res_o
    );

endinterface

// File: rtl/alu_mul_shift.sv
// Iterative unsigned shift-add multiplier: loads on start, iterates DATA_W cycles, then raises done for one cycle.
module alu_mul_shift #(
    parameter int DATA_W = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [DATA_W-1:0]     x,
    input  logic [DATA_W-1:0]     y,
    output logic                  done,
    output logic [2*DATA_W-1:0]   product
);
    localparam int RES_W = 2 * DATA_W;
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              running_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic [RES_W-1:0]  acc_reg;
    logic [RES_W-1:0]  mcand_reg;
    logic [DATA_W-1:0] mplier_reg;

    // mcand is shifted left each step, so adding it equals adding x << i.
    always_ff @(posedge clk) begin
        if (reset) begin
            running_reg <= 1'b0;
            cnt_reg     <= '0;
            acc_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
        end else if (start) begin
            running_reg <= 1'b1;
            cnt_reg     <= CNT_W'(DATA_W);
            acc_reg     <= '0;
            mcand_reg   <= RES_W'(x);
            mplier_reg  <= y;
        end else if (running_reg) begin
            if (cnt_reg != '0) begin
                if (mplier_reg[0]) begin
                    acc_reg <= acc_reg + mcand_reg;
                end
                mcand_reg  <= mcand_reg << 1;
                mplier_reg <= mplier_reg >> 1;
                cnt_reg    <= cnt_reg - 1'b1;
            end else begin
                running_reg <= 1'b0;
            end
        end
    end

    assign done    = running_reg && (cnt_reg == '0);
    assign product = acc_reg;

endmodule

// File: rtl/alu_arb_seq.sv
// Round-robin arbiter and sequencer sharing one small ALU between two requesters.
// Define ALU_ARB_STATUS_EN to add registered zero/negative result flags.
module alu_arb_seq
    import alu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    alu_arb_seq_if.slave  bus
);
    localparam int RES_W = 2 * DATA_W;

    state_t            state_reg;
    logic              last_grant_reg;
    logic [1:0]        op_reg;
    logic [DATA_W-1:0] x_reg;
    logic [DATA_W-1:0] y_reg;
    logic              id_reg;
    logic              res_id_reg;
    logic [RES_W-1:0]  res_reg;
    logic              valid_reg;

    logic              grant_any;
    logic              grant;
    logic [1:0]        sel_op;
    logic [DATA_W-1:0] sel_x;
    logic [DATA_W-1:0] sel_y;
    logic              mul_start;
    logic              mul_done;
    logic [RES_W-1:0]  mul_prod;
    logic [DATA_W:0]   sum_ext;
    logic [DATA_W:0]   diff_ext;
    logic [RES_W-1:0]  exec_res;

    // On a tie the requester that did not win last time is granted.
    assign grant_any = (state_reg == IDLE) && (bus.req_i != 2'b00);
    assign grant     = (bus.req_i == 2'b11) ? ~last_grant_reg : bus.req_i[1];
    assign sel_op    = grant ? bus.op1_i : bus.op0_i;
    assign sel_x     = grant ? bus.x1_i  : bus.x0_i;
    assign sel_y     = grant ? bus.y1_i  : bus.y0_i;
    assign mul_start = grant_any && (sel_op == OP_MUL);

    for (genvar gi = 0; gi < 2; gi++) begin : g_ack
        assign bus.ack_o[gi] = grant_any && (grant == 1'(gi));
    end

    alu_mul_shift #(.DATA_W(DATA_W)) u_mul (
        .clk     (clk),
        .reset   (reset),
        .start   (mul_start),
        .x       (sel_x),
        .y       (sel_y),
        .done    (mul_done),
        .product (mul_prod)
    );

    // One extra bit keeps the add carry and the subtract sign.
    assign sum_ext  = {1'b0, x_reg} + {1'b0, y_reg};
    assign diff_ext = {1'b0, x_reg} - {1'b0, y_reg};

    always_comb begin
        exec_res = '0;
        case (op_reg)
            OP_ADD:  exec_res = RES_W'(sum_ext);
            OP_SUB:  exec_res = {{(RES_W-DATA_W-1){diff_ext[DATA_W]}}, diff_ext};
            OP_PASS: exec_res = RES_W'(x_reg);
            default: exec_res = '0;
        endcase
    end

`ifdef ALU_ARB_STATUS_EN
    logic zero_reg;
    logic neg_reg;
    assign bus.zero_o = zero_reg;
    assign bus.neg_o  = neg_reg;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            last_grant_reg <= 1'b1;
            op_reg         <= OP_ADD;
            x_reg          <= '0;
            y_reg          <= '0;
            id_reg         <= 1'b0;
            res_id_reg     <= 1'b0;
            res_reg        <= '0;
            valid_reg      <= 1'b0;
`ifdef ALU_ARB_STATUS_EN
            zero_reg       <= 1'b0;
            neg_reg        <= 1'b0;
`endif
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (grant_any) begin
                        op_reg         <= sel_op;
                        x_reg          <= sel_x;
                        y_reg          <= sel_y;
                        id_reg         <= grant;
                        last_grant_reg <= grant;
                        state_reg      <= (sel_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    res_reg    <= exec_res;
                    res_id_reg <= id_reg;
                    valid_reg  <= 1'b1;
`ifdef ALU_ARB_STATUS_EN
                    zero_reg   <= (exec_res == '0);
                    neg_reg    <= (op_reg == OP_SUB) && exec_res[RES_W-1];
`endif
                    state_reg  <= IDLE;
                end
                MUL: begin
                    if (mul_done) begin
                        res_reg    <= mul_prod;
                        res_id_reg <= id_reg;
                        valid_reg  <= 1'b1;
`ifdef ALU_ARB_STATUS_EN
                        zero_reg   <= (mul_prod == '0);
                        neg_reg    <= 1'b0;
`endif
                        state_reg  <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.busy_o      = (state_reg != IDLE);
    assign bus.res_valid_o = valid_reg;
    assign bus.res_id_o    = res_id_reg;
    assign bus.res_o       = res_reg;

endmodule

// File: tb/tb_alu_arb_seq.sv
// Directed bench for alu_arb_seq: stimulus pushes expected results into a scoreboard, a monitor pops and compares.
module tb_alu_arb_seq;
    import alu_pkg::*;

    typedef struct {
        logic       id;
        logic [7:0] res;
        logic       zero;
        logic       neg;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    alu_arb_seq_if #(.DATA_W(4)) bus();

    alu_arb_seq #(.DATA_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Raise req with the given mask, wait for an ack, check which requester won and queue its result.
    task automatic issue(input logic [1:0] mask, input logic exp_id, input logic [7:0] exp_res,
                         input logic exp_zero, input logic exp_neg, input int lat);
        bit   got = 0;
        exp_t e;
        bus.req_i = mask;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (bus.ack_o != 2'b00) begin
                got = 1;
                check("ack", 32'(bus.ack_o), 32'(2'b01 << exp_id));
                e.id = exp_id; e.res = exp_res; e.zero = exp_zero; e.neg = exp_neg; e.due = cyc + lat;
                sb.push_back(e);
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ack_timeout: got no ack, required ack for requester %0d", exp_id);
        end
        @(posedge clk); #1;
        bus.req_i = 2'b00;
    endtask

    task automatic drain();
        bit empty = 0;
        for (int k = 0; k < 30 && !empty; k++) begin
            @(posedge clk);
            empty = (sb.size() == 0);
        end
        #1;
        if (!empty) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending results, required 0", sb.size());
        end
    endtask

    task automatic check_reset_state(input string tag);
        @(negedge clk);
        check({tag, "_busy"},   32'(bus.busy_o),      32'd0);
        check({tag, "_valid"},  32'(bus.res_valid_o), 32'd0);
        check({tag, "_res"},    32'(bus.res_o),       32'd0);
        check({tag, "_res_id"}, 32'(bus.res_id_o),    32'd0);
        check({tag, "_ack"},    32'(bus.ack_o),       32'd0);
`ifdef ALU_ARB_STATUS_EN
        check({tag, "_zero"},   32'(bus.zero_o),      32'd0);
        check({tag, "_neg"},    32'(bus.neg_o),       32'd0);
`endif
    endtask

    // Monitor: every result strobe must match the oldest queued expectation, including its cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus.res_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_result: got res=%02h id=%0d, required no strobe", bus.res_o, bus.res_id_o);
                end else begin
                    e = sb.pop_front();
                    $display("txn cyc=%0d id=%0d res=%02h", cyc, bus.res_id_o, bus.res_o);
                    check("res",     32'(bus.res_o),    32'(e.res));
                    check("res_id",  32'(bus.res_id_o), 32'(e.id));
                    check("latency", 32'(cyc),          32'(e.due));
`ifdef ALU_ARB_STATUS_EN
                    check("zero",    32'(bus.zero_o),   32'(e.zero));
                    check("neg",     32'(bus.neg_o),    32'(e.neg));
`endif
                end
            end
        end
    end

    initial begin
        bit   exp_id;
        int   n;
        int   t0;
        exp_t e;
        bus.req_i = 2'b00;
        bus.op0_i = OP_ADD; bus.x0_i = '0; bus.y0_i = '0;
        bus.op1_i = OP_ADD; bus.x1_i = '0; bus.y1_i = '0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        check_reset_state("reset");
        @(posedge clk); #1;

        // add 9+7 from requester 0
        bus.op0_i = OP_ADD; bus.x0_i = 4'd9; bus.y0_i = 4'd7;
        issue(2'b01, 1'b0, 8'h10, 1'b0, 1'b0, 2);
        drain();

        // sub 3-5 from requester 1
        bus.op1_i = OP_SUB; bus.x1_i = 4'd3; bus.y1_i = 4'd5;
        issue(2'b10, 1'b1, 8'hFE, 1'b0, 1'b1, 2);
        drain();

        // add carry and pass
        bus.op0_i = OP_ADD; bus.x0_i = 4'd15; bus.y0_i = 4'd15;
        issue(2'b01, 1'b0, 8'h1E, 1'b0, 1'b0, 2);
        drain();
        bus.op1_i = OP_PASS; bus.x1_i = 4'd11; bus.y1_i = 4'd6;
        issue(2'b10, 1'b1, 8'h0B, 1'b0, 1'b0, 2);
        drain();

        // mul 15*15 with requester 1 arriving mid-operation
        bus.op0_i = OP_MUL; bus.x0_i = 4'd15; bus.y0_i = 4'd15;
        bus.op1_i = OP_PASS; bus.x1_i = 4'd5; bus.y1_i = 4'd0;
        bus.req_i = 2'b01;
        @(negedge clk);
        check("mul_ack", 32'(bus.ack_o), 32'd1);
        t0 = cyc;
        e.id = 1'b0; e.res = 8'hE1; e.zero = 1'b0; e.neg = 1'b0; e.due = t0 + 6;
        sb.push_back(e);
        for (int k = 1; k <= 5; k++) begin
            @(posedge clk); #1;
            if (k == 1) bus.req_i = 2'b00;
            if (k == 2) bus.req_i = 2'b10;
            @(negedge clk);
            check("mul_busy", 32'(bus.busy_o), 32'd1);
            if (k >= 2) check("mul_wait_ack", 32'(bus.ack_o), 32'd0);
        end
        @(posedge clk); #1;
        @(negedge clk);
        check("late_ack", 32'(bus.ack_o), 32'd2);
        e.id = 1'b1; e.res = 8'h05; e.zero = 1'b0; e.neg = 1'b0; e.due = cyc + 2;
        sb.push_back(e);
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        drain();

        // both requesters held: grants alternate 0,1,0,1
        bus.op0_i = OP_PASS; bus.x0_i = 4'd1; bus.y0_i = 4'd0;
        bus.op1_i = OP_PASS; bus.x1_i = 4'd2; bus.y1_i = 4'd0;
        bus.req_i = 2'b11;
        exp_id = 1'b0;
        n = 0;
        for (int k = 0; k < 20 && n < 4; k++) begin
            @(negedge clk);
            if (bus.ack_o != 2'b00) begin
                check("alt_grant", 32'(bus.ack_o), 32'(2'b01 << exp_id));
                e.id = exp_id; e.res = exp_id ? 8'h02 : 8'h01; e.zero = 1'b0; e.neg = 1'b0; e.due = cyc + 2;
                sb.push_back(e);
                exp_id = ~exp_id;
                n++;
            end
        end
        check("alt_count", 32'(n), 32'd4);
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        drain();

        // reset during a mul aborts it and restores the tie-break to requester 0
        bus.op0_i = OP_MUL; bus.x0_i = 4'd3; bus.y0_i = 4'd4;
        bus.req_i = 2'b01;
        @(negedge clk);
        check("abort_ack", 32'(bus.ack_o), 32'd1);
        @(posedge clk); #1;
        bus.req_i = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_reset_state("abort");
        repeat (8) @(posedge clk);
        #1;
        bus.op0_i = OP_PASS; bus.x0_i = 4'd1;
        bus.op1_i = OP_PASS; bus.x1_i = 4'd2;
        issue(2'b11, 1'b0, 8'h01, 1'b0, 1'b0, 2);
        drain();

        // 0-0 gives a zero result
        bus.op0_i = OP_SUB; bus.x0_i = 4'd0; bus.y0_i = 4'd0;
        issue(2'b01, 1'b0, 8'h00, 1'b1, 1'b0, 2);
        drain();

        repeat (3) @(posedge clk);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
